fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the decode stage.
- Maintains the fetch PC and issues one instruction-memory request at a time over a valid/ready request and valid response interface.
- Buffers returned words with their PCs and presents {insn, pc, valid_insn} to decode, one instruction per cycle.
- Honours a stall from downstream and a branch/jump redirect from execute.

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_buffer.sv | 81 ++++++++
 rtl/fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset
// address, PC step, FSM state encoding and the buffered entry layout.
package fetch_stage_pkg;

  localparam int          INSN_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8002_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Fetch FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // One buffered instruction together with the address it came from
  typedef struct packed {
    logic [INSN_W-1:0] pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

  // Instructions are word aligned: drop the byte offset of a target address
  function automatic logic [INSN_W-1:0] align_pc(input logic [INSN_W-1:0] addr);
    return {addr[INSN_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, insn} entries between the memory
// response path and the decode output register. Flush wins over push/pop.
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head,
  output logic               empty,
  output logic               full,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];
  assign do_pop = pop && !empty;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

`ifndef SYNTHESIS
  // The fetch stage reserves a slot before requesting, so this must never happen
  push_when_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full))
    else $error("fetch_buffer: push while full");
`endif

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: walks the fetch PC, issues one memory request
// at a time, buffers returned words with their PCs and presents one
// instruction per cycle to decode, honouring stall and redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        valid_insn
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [1:0]        state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic [31:0]       insn_q, insn_d;
  logic [31:0]       pc_q, pc_d;
  logic              valid_q, valid_d;

  logic              buf_push, buf_pop, buf_flush;
  logic              buf_empty, buf_full;
  logic [CNT_W-1:0]  buf_count;
  fetch_entry_t      buf_head, buf_wdata;
  logic              has_room;
  logic              req_accept;

  // Requests are only made from FETCH, where nothing is outstanding, so
  // occupancy alone decides whether a returning word has a slot.
  assign has_room       = (buf_count < CNT_W'(BUF_DEPTH));
  assign imem_req_valid = (state_q == ST_FETCH) && has_room;
  assign imem_req_addr  = fetch_pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;

  assign buf_wdata.pc   = req_pc_q;
  assign buf_wdata.insn = imem_rsp_data;

  assign insn       = insn_q;
  assign pc         = pc_q;
  assign valid_insn = valid_q;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (buf_wdata),
    .pop       (buf_pop),
    .flush     (buf_flush),
    .head      (buf_head),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

  // Fetch FSM: request/response sequencing, with redirect overriding everything
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    buf_push   = 1'b0;
    buf_flush  = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (req_accept) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_INC;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          buf_push = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // The word for the abandoned path is dropped on the floor
        if (imem_rsp_valid) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect) begin
      buf_flush  = 1'b1;
      buf_push   = 1'b0;
      fetch_pc_d = align_pc(redirect_pc);
      case (state_q)
        // A request accepted this cycle belongs to the old path: drain it
        ST_FETCH: state_d = req_accept ? ST_DRAIN : ST_FETCH;
        // Still waiting on an old-path word unless it lands right now
        ST_WAIT,
        ST_DRAIN: state_d = imem_rsp_valid ? ST_FETCH : ST_DRAIN;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  // Decode-facing output register: load from buffer head unless stalled
  always_comb begin
    insn_d  = insn_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    buf_pop = 1'b0;
    if (redirect) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      if (!buf_empty) begin
        insn_d  = buf_head.insn;
        pc_d    = buf_head.pc;
        valid_d = 1'b1;
        buf_pop = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // FSM and PC state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // Output register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insn_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      insn_q  <= insn_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

`ifndef SYNTHESIS
  // A request with no free slot would overflow the buffer when it returns
  req_when_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_req_valid && buf_full))
    else $error("fetch_stage: request issued with full buffer");
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a simple memory model answers accepted
// requests after a programmable latency; each task checks one scenario.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        valid_insn;

  int n_pass  = 0;
  int n_total = 0;

  // memory model state
  int          mem_lat;
  int          rsp_cnt;
  logic [31:0] rsp_word;
  logic        acc;
  logic [31:0] acc_addr;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (32'h8002_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .insn           (insn),
    .pc             (pc),
    .valid_insn     (valid_insn)
  );

  // Memory contents: the reset vector holds a known word, others are derived
  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h8002_0000) return 32'h2408_0005;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Advance one clock; acceptance is sampled mid-cycle, responses driven after the edge
  task automatic step();
    @(negedge clk);
    acc      = rst_n && imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      rsp_word = word_of(acc_addr);
      rsp_cnt  = mem_lat;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = rsp_word;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    mem_lat = 1; rsp_cnt = 0; acc = 1'b0; acc_addr = '0; rsp_word = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); else n_pass++;
    n_total++; if (insn !== 32'h0) $display("FAIL reset_insn: got %h expected 00000000", insn); else n_pass++;
    n_total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected 00000000", pc); else n_pass++;
    n_total++; if (valid_insn !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_insn); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL idle_req_valid: got %b expected 0", imem_req_valid); else n_pass++;
    $display("reset: outputs cleared, IDLE after release");
  endtask

  task automatic test_first_fetch();
    step();
    n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8002_0000}) $display("FAIL first_req: got %b/%h expected 1/80020000", imem_req_valid, imem_req_addr); else n_pass++;
    step();
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL wait_req_valid: got %b expected 0", imem_req_valid); else n_pass++;
    step();
    n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8002_0004}) $display("FAIL second_req: got %b/%h expected 1/80020004", imem_req_valid, imem_req_addr); else n_pass++;
    n_total++; if (valid_insn !== 1'b0) $display("FAIL no_bypass: got valid %b expected 0", valid_insn); else n_pass++;
    step();
    n_total++; if ({valid_insn, pc, insn} !== {1'b1, 32'h8002_0000, 32'h2408_0005}) $display("FAIL first_insn: got %b/%h/%h expected 1/80020000/24080005", valid_insn, pc, insn); else n_pass++;
    $display("first_fetch: pc=%h insn=%h", pc, insn);
  endtask

  task automatic test_stall_full();
    logic [31:0] exp_pc [3];
    int          nv;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++; if ({valid_insn, pc, insn} !== {1'b1, 32'h8002_0000, 32'h2408_0005}) $display("FAIL stall_hold_%0d: got %b/%h/%h expected 1/80020000/24080005", i, valid_insn, pc, insn); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      n_total++; if (imem_req_valid !== 1'b0) $display("FAIL full_no_req_%0d: got %b expected 0", i, imem_req_valid); else n_pass++;
      step();
    end
    stall = 1'b0;
    exp_pc[0] = 32'h8002_0004; exp_pc[1] = 32'h8002_0008; exp_pc[2] = 32'h8002_000C;
    nv = 0;
    for (int i = 0; i < 30 && nv < 3; i++) begin
      step();
      if (valid_insn) begin
        n_total++; if ({pc, insn} !== {exp_pc[nv], exp_pc[nv] ^ 32'h5A5A_0000}) $display("FAIL resume_%0d: got %h/%h expected %h/%h", nv, pc, insn, exp_pc[nv], exp_pc[nv] ^ 32'h5A5A_0000); else n_pass++;
        nv++;
      end
    end
    n_total++; if (nv != 3) $display("FAIL resume_timeout: got %0d insns expected 3", nv); else n_pass++;
    $display("stall_full: held 5 cycles, resumed with %0d insns", nv);
  endtask

  task automatic test_redirect_wait();
    logic found;
    mem_lat = 4;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (acc) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL rw_accept_timeout: got none expected accept"); else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h8002_0103;
    step();
    redirect = 1'b0;
    n_total++; if ({valid_insn, imem_req_valid} !== 2'b00) $display("FAIL rw_after_redirect: got valid/req %b%b expected 00", valid_insn, imem_req_valid); else n_pass++;
    step();
    step();
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL rw_drain_req: got %b expected 0", imem_req_valid); else n_pass++;
    step();
    n_total++; if ({imem_req_valid, imem_req_addr, valid_insn} !== {1'b1, 32'h8002_0100, 1'b0}) $display("FAIL rw_new_req: got %b/%h/%b expected 1/80020100/0", imem_req_valid, imem_req_addr, valid_insn); else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (valid_insn) found = 1'b1;
    end
    n_total++; if ({found, pc, insn} !== {1'b1, 32'h8002_0100, 32'hDA58_0100}) $display("FAIL rw_first_new: got %b/%h/%h expected 1/80020100/da580100", found, pc, insn); else n_pass++;
    mem_lat = 1;
    $display("redirect_wait: first new pc=%h", pc);
  endtask

  task automatic test_redirect_rsp_stall();
    logic found;
    stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (imem_rsp_valid && valid_insn) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL rr_setup_timeout: got none expected rsp with valid output"); else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h8003_0000;
    step();
    redirect = 1'b0;
    n_total++; if (valid_insn !== 1'b0) $display("FAIL rr_valid_cleared: got %b expected 0", valid_insn); else n_pass++;
    n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8003_0000}) $display("FAIL rr_req: got %b/%h expected 1/80030000", imem_req_valid, imem_req_addr); else n_pass++;
    step();
    step();
    n_total++; if (valid_insn !== 1'b0) $display("FAIL rr_stall_hold: got %b expected 0", valid_insn); else n_pass++;
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (valid_insn) found = 1'b1;
    end
    n_total++; if ({found, pc, insn} !== {1'b1, 32'h8003_0000, 32'hDA59_0000}) $display("FAIL rr_first_new: got %b/%h/%h expected 1/80030000/da590000", found, pc, insn); else n_pass++;
    $display("redirect_rsp_stall: first new pc=%h", pc);
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [2];
    logic [31:0] vpc [2];
    logic [31:0] vinsn [2];
    int          na, nv;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    na = 0; nv = 0;
    for (int i = 0; i < 40 && (na < 2 || nv < 2); i++) begin
      if (imem_req_valid && na < 2) begin
        if (na == 0 || imem_req_addr != addrs[na-1]) begin
          addrs[na] = imem_req_addr;
          na++;
        end
      end
      step();
      if (valid_insn && nv < 2) begin
        vpc[nv]   = pc;
        vinsn[nv] = insn;
        nv++;
      end
    end
    n_total++; if (na != 2 || nv != 2) $display("FAIL wrap_timeout: got %0d reqs %0d insns expected 2 and 2", na, nv); else n_pass++;
    if (na == 2) begin
      n_total++; if (addrs[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_req0: got %h expected fffffffc", addrs[0]); else n_pass++;
      n_total++; if (addrs[1] !== 32'h0000_0000) $display("FAIL wrap_req1: got %h expected 00000000", addrs[1]); else n_pass++;
    end
    if (nv == 2) begin
      n_total++; if ({vpc[0], vinsn[0]} !== {32'hFFFF_FFFC, 32'hA5A5_FFFC}) $display("FAIL wrap_insn0: got %h/%h expected fffffffc/a5a5fffc", vpc[0], vinsn[0]); else n_pass++;
      n_total++; if ({vpc[1], vinsn[1]} !== {32'h0000_0000, 32'h5A5A_0000}) $display("FAIL wrap_insn1: got %h/%h expected 00000000/5a5a0000", vpc[1], vinsn[1]); else n_pass++;
    end
    $display("wrap: reqs=%0d insns=%0d", na, nv);
  endtask

  task automatic test_reset_mid_wait();
    logic found;
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (acc) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL rm_accept_timeout: got none expected accept"); else n_pass++;
    step();
    rst_n = 1'b0;
    #1;
    n_total++; if ({imem_req_valid, valid_insn, pc, insn} !== {2'b00, 64'h0}) $display("FAIL rm_async_clear: got %b%b/%h/%h expected 00/00000000/00000000", imem_req_valid, valid_insn, pc, insn); else n_pass++;
    step();
    rst_n = 1'b1;
    n_total++; if (imem_rsp_valid !== 1'b1) $display("FAIL rm_stray_setup: got rsp %b expected 1", imem_rsp_valid); else n_pass++;
    step();
    n_total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8002_0000}) $display("FAIL rm_restart_req: got %b/%h expected 1/80020000", imem_req_valid, imem_req_addr); else n_pass++;
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (valid_insn) found = 1'b1;
    end
    n_total++; if ({found, pc, insn} !== {1'b1, 32'h8002_0000, 32'h2408_0005}) $display("FAIL rm_first_insn: got %b/%h/%h expected 1/80020000/24080005", found, pc, insn); else n_pass++;
    $display("reset_mid_wait: restarted at pc=%h", pc);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_full();
    test_redirect_wait();
    test_redirect_rsp_stall();
    test_wrap();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
